// File: rtl/module_knob_accumulator.sv
// Front-panel detent accumulator: turns detent pulses into a bounded value with
// speed-dependent acceleration, a parallel preset path and a change strobe.
module module_knob_accumulator #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MAX_VAL     = 255,
    parameter int unsigned RESET_VAL   = 0,
    parameter int unsigned FAST_WINDOW = 1000000,
    parameter int unsigned STREAK_LEN  = 4,
    parameter int unsigned FAST_STEP   = 16
) (
    input  logic             qzt_clk,
    input  logic             reset_n,
    input  logic             pulse,
    input  logic             direction,
    input  logic             wrap_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             changed,
    output logic             at_min,
    output logic             at_max
);

    localparam int unsigned AW    = WIDTH + 1;
    localparam int unsigned GAP_W = $clog2(FAST_WINDOW + 2);
    localparam int unsigned STK_W = $clog2(STREAK_LEN + 1);

    localparam logic [AW-1:0]    MAX_A    = AW'(MAX_VAL);
    localparam logic [AW-1:0]    RANGE_A  = AW'(MAX_VAL + 1);
    localparam logic [AW-1:0]    FSTEP_A  = AW'(FAST_STEP);
    localparam logic [GAP_W-1:0] GAP_SAT  = GAP_W'(FAST_WINDOW + 1);
    localparam logic [GAP_W-1:0] GAP_FAST = GAP_W'(FAST_WINDOW);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STREAK_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_FAST
    } state_e;

    state_e             state_q, state_d;
    logic               dir_q, dir_d;
    logic [STK_W-1:0]   streak_q, streak_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic               changed_q, changed_d;
    logic               at_min_q, at_min_d;
    logic               at_max_q, at_max_d;

    logic               fast_c;
    logic               same_dir_c;
    logic [STK_W-1:0]   streak_inc_c;
    logic [AW-1:0]      step_c;
    logic [AW-1:0]      cur_a_c;
    logic [AW-1:0]      sum_c;
    logic [AW-1:0]      load_a_c;
    logic [WIDTH-1:0]   stepped_c;

    assign fast_c       = (gap_q <= GAP_FAST);
    assign same_dir_c   = (direction == dir_q);
    assign streak_inc_c = (streak_q == STK_MAX) ? STK_MAX : streak_q + STK_W'(1);
    assign cur_a_c      = {1'b0, value_q};
    assign sum_c        = cur_a_c + step_c;
    assign load_a_c     = {1'b0, load_value};

    // Pacing FSM: chooses the step size and tracks streak / direction history.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        streak_d = streak_q;
        step_c   = AW'(1);
        gap_d    = (gap_q == GAP_SAT) ? GAP_SAT : gap_q + GAP_W'(1);

        if (load) begin
            state_d  = S_IDLE;
            streak_d = '0;
            gap_d    = GAP_SAT;
        end else if (pulse) begin
            gap_d = GAP_W'(1);
            if (state_q == S_TRACK && fast_c && same_dir_c) begin
                streak_d = streak_inc_c;
                state_d  = (streak_inc_c == STK_MAX) ? S_FAST : S_TRACK;
            end else if (state_q == S_FAST && fast_c && same_dir_c) begin
                step_c   = FSTEP_A;
            end else begin
                // Fresh start: idle, slow pulse or direction reversal.
                streak_d = STK_W'(1);
                dir_d    = direction;
                state_d  = S_TRACK;
            end
        end else if (state_q != S_IDLE && gap_q == GAP_SAT) begin
            state_d = S_IDLE;
        end
    end

    // Bounded add/subtract at WIDTH+1 bits with wrap or saturate.
    always_comb begin
        stepped_c = value_q;
        if (!direction) begin
            if (sum_c > MAX_A) begin
                stepped_c = wrap_en ? WIDTH'(sum_c - RANGE_A) : WIDTH'(MAX_VAL);
            end else begin
                stepped_c = WIDTH'(sum_c);
            end
        end else begin
            if (cur_a_c >= step_c) begin
                stepped_c = WIDTH'(cur_a_c - step_c);
            end else begin
                stepped_c = wrap_en ? WIDTH'(cur_a_c + RANGE_A - step_c) : '0;
            end
        end
    end

    // Value update and the status flags derived from the next value.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (load_a_c > MAX_A) ? WIDTH'(MAX_VAL) : load_value;
        end else if (pulse) begin
            value_d = stepped_c;
        end
        changed_d = (value_d != value_q);
        at_min_d  = (value_d == '0);
        at_max_d  = ({1'b0, value_d} == MAX_A);
    end

    always_ff @(posedge qzt_clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            streak_q  <= '0;
            gap_q     <= GAP_SAT;
            value_q   <= WIDTH'(RESET_VAL);
            changed_q <= 1'b0;
            at_min_q  <= (RESET_VAL == 0);
            at_max_q  <= (RESET_VAL == MAX_VAL);
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            streak_q  <= streak_d;
            gap_q     <= gap_d;
            value_q   <= value_d;
            changed_q <= changed_d;
            at_min_q  <= at_min_d;
            at_max_q  <= at_max_d;
        end
    end

    assign value   = value_q;
    assign changed = changed_q;
    assign at_min  = at_min_q;
    assign at_max  = at_max_q;

endmodule

// File: tb/tb_module_knob_accumulator.sv
// Bench for module_knob_accumulator: directed scenarios plus random traffic,
// every cycle compared against a pulse-history reference model.
module tb_module_knob_accumulator;

    localparam int W   = 5;
    localparam int MX  = 20;
    localparam int RV  = 0;
    localparam int FW  = 8;
    localparam int SL  = 3;
    localparam int FS  = 4;

    logic         qzt_clk;
    logic         reset_n;
    logic         pulse;
    logic         direction;
    logic         wrap_en;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] value;
    logic         changed;
    logic         at_min;
    logic         at_max;

    module_knob_accumulator #(
        .WIDTH      (W),
        .MAX_VAL    (MX),
        .RESET_VAL  (RV),
        .FAST_WINDOW(FW),
        .STREAK_LEN (SL),
        .FAST_STEP  (FS)
    ) dut (
        .qzt_clk   (qzt_clk),
        .reset_n   (reset_n),
        .pulse     (pulse),
        .direction (direction),
        .wrap_en   (wrap_en),
        .load      (load),
        .load_value(load_value),
        .value     (value),
        .changed   (changed),
        .at_min    (at_min),
        .at_max    (at_max)
    );

    initial qzt_clk = 1'b0;
    always #5 qzt_clk = ~qzt_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: value plus history of accepted pulses.
    int m_val    = RV;
    int m_chg    = 0;
    int m_streak = 0;
    int m_dir    = 0;
    int m_last   = 0;
    int m_has    = 0;
    int m_cyc    = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rn, input bit p, input bit d, input bit w,
                              input bit l, input int lv);
        int nv;
        int stp;
        bit fast;
        nv = m_val;
        if (!rn) begin
            nv       = RV;
            m_streak = 0;
            m_has    = 0;
            m_chg    = 0;
            m_val    = nv;
        end else if (l) begin
            nv       = (lv > MX) ? MX : lv;
            m_chg    = (nv != m_val);
            m_val    = nv;
            m_streak = 0;
            m_has    = 0;
        end else if (p) begin
            fast = (m_has != 0) && ((m_cyc - m_last) <= FW);
            if (m_streak > 0 && fast && (int'(d) == m_dir)) begin
                stp      = (m_streak >= SL) ? FS : 1;
                m_streak = (m_streak + 1 > SL) ? SL : m_streak + 1;
            end else begin
                stp      = 1;
                m_streak = 1;
                m_dir    = int'(d);
            end
            if (!d) begin
                if (m_val + stp > MX) nv = w ? (m_val + stp - (MX + 1)) : MX;
                else                  nv = m_val + stp;
            end else begin
                if (m_val >= stp) nv = m_val - stp;
                else              nv = w ? (m_val - stp + MX + 1) : 0;
            end
            m_chg  = (nv != m_val);
            m_val  = nv;
            m_last = m_cyc;
            m_has  = 1;
        end else begin
            m_chg = 0;
        end
        m_cyc++;
    endtask

    // One clock: drive, advance model at the edge, compare 1 time unit later.
    task automatic cyc(input bit rn, input bit p, input bit d, input bit w,
                       input bit l, input int lv);
        reset_n    = rn;
        pulse      = p;
        direction  = d;
        wrap_en    = w;
        load       = l;
        load_value = W'(lv);
        @(posedge qzt_clk);
        model_edge(rn, p, d, w, l, lv);
        #1;
        check_eq("value",   int'(value),   m_val);
        check_eq("changed", int'(changed), m_chg);
        check_eq("at_min",  int'(at_min),  int'(m_val == 0));
        check_eq("at_max",  int'(at_max),  int'(m_val == MX));
    endtask

    task automatic idle(input int n, input bit w);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, w, 1'b0, 0);
    endtask

    task automatic pulse_at(input int spacing, input bit d, input bit w);
        idle(spacing - 1, w);
        cyc(1'b1, 1'b1, d, w, 1'b0, 0);
    endtask

    task automatic do_load(input int lv);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, lv);
    endtask

    initial begin
        int exp_acc [6] = '{1, 2, 3, 7, 11, 15};
        int exp_wrap[4] = '{20, 0, 1, 5};
        int sp;
        bit rd;

        // Reset, then decrement at the lower bound.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_eq("reset_value", int'(value), 0);
        check_eq("reset_at_min", int'(at_min), 1);
        idle(2, 1'b0);
        pulse_at(1, 1'b1, 1'b0);
        check_eq("dec_sat_value", int'(value), 0);
        check_eq("dec_sat_changed", int'(changed), 0);

        // Slow increments: step 1 each.
        for (int i = 0; i < 5; i++) begin
            pulse_at(20, 1'b0, 1'b0);
            check_eq("slow_inc", int'(value), i + 1);
            check_eq("slow_inc_chg", int'(changed), 1);
        end

        // Acceleration, then direction reversal restarts the streak.
        do_load(0);
        idle(12, 1'b0);
        for (int i = 0; i < 6; i++) begin
            pulse_at(3, 1'b0, 1'b0);
            check_eq("accel", int'(value), exp_acc[i]);
        end
        pulse_at(3, 1'b1, 1'b0);
        check_eq("reverse1", int'(value), 14);
        pulse_at(3, 1'b1, 1'b0);
        check_eq("reverse2", int'(value), 13);

        // Wrap through the top bound, then saturate there.
        do_load(19);
        for (int i = 0; i < 4; i++) begin
            pulse_at(1, 1'b0, 1'b1);
            check_eq("wrap", int'(value), exp_wrap[i]);
        end
        do_load(19);
        for (int i = 0; i < 4; i++) begin
            pulse_at(1, 1'b0, 1'b0);
            check_eq("sat_top", int'(value), 20);
        end
        check_eq("sat_top_at_max", int'(at_max), 1);
        check_eq("sat_top_changed", int'(changed), 0);

        // Load beats a same-cycle pulse and clamps.
        do_load(5);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 31);
        check_eq("load_clamp", int'(value), 20);
        check_eq("load_clamp_chg", int'(changed), 1);
        idle(1, 1'b0);
        check_eq("load_one_strobe", int'(changed), 0);
        pulse_at(1, 1'b1, 1'b0);
        check_eq("after_load_step", int'(value), 19);
        do_load(19);
        check_eq("load_same_nochg", int'(changed), 0);

        // Reset mid-spin discards acceleration.
        do_load(0);
        for (int i = 0; i < 4; i++) pulse_at(1, 1'b0, 1'b0);
        check_eq("prespin", int'(value), 7);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        pulse_at(1, 1'b0, 1'b0);
        check_eq("post_reset_step", int'(value), 1);

        // Random traffic against the model.
        rd = 1'b0;
        for (int ev = 0; ev < 400; ev++) begin
            sp = int'($urandom_range(1, 12));
            if ($urandom_range(0, 5) == 0) rd = ~rd;
            idle(sp - 1, 1'($urandom_range(0, 1)));
            case ($urandom_range(0, 39))
                0:       cyc(1'b0, 1'b1, rd, 1'b0, 1'b0, 0);
                1, 2:    cyc(1'b1, 1'b0, rd, 1'b0, 1'b1, int'($urandom_range(0, 31)));
                3:       cyc(1'b1, 1'b1, rd, 1'b1, 1'b1, int'($urandom_range(0, 31)));
                default: cyc(1'b1, 1'b1, rd, 1'($urandom_range(0, 1)), 1'b0, 0);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
